// File: rtl/osd_icon_sched.sv
// Read-side scheduler for the icon overlay ROM banks: key debounce, bank stepping,
// frame-latched window position, ROM address/enable generation and latency-aligned valid.
module osd_icon_sched #(
  parameter int ICON_W       = 50,
  parameter int ICON_H       = 50,
  parameter int ROM_AW       = 12,
  parameter int ROM_LAT      = 1,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int NUM_BANKS    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       pixel_x,
  input  logic [11:0]       pixel_y,
  input  logic              de,
  input  logic              frame_start,
  input  logic              key_raw,
  input  logic [11:0]       pos_x,
  input  logic [11:0]       pos_y,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_en,
  output logic [2:0]        bank_sel,
  output logic              ovl_valid
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int AREA = ICON_W * ICON_H;
  localparam int AW1  = ROM_AW + 1;
  localparam logic [ROM_AW-1:0] ADDR_LAST = ROM_AW'(AREA - 1);

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_B1  = 3'd1,
    S_B2  = 3'd2,
    S_B3  = 3'd3,
    S_B4  = 3'd4,
    S_B5  = 3'd5,
    S_B6  = 3'd6,
    S_B7  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_key_s1;
  logic            r_key_s2;
  logic            r_key_s2_d;
  logic            r_key_db;
  logic            r_key_db_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_key_pulse;

  logic [11:0]        r_px;
  logic [11:0]        r_py;
  logic [2:0]         r_bank_sel;
  logic [ROM_AW-1:0]  r_cnt;
  logic [ROM_AW-1:0]  r_row_base;
  logic               r_active_d;
  logic [ROM_AW-1:0]  r_rom_addr;
  logic               r_rom_en;
  logic [ROM_LAT-1:0] r_en_pipe;

  logic [12:0]       w_x_end;
  logic [12:0]       w_y_end;
  logic              w_in_win;
  logic              w_active;
  logic              w_row_start;
  logic [ROM_AW-1:0] w_addr;
  logic [ROM_AW-1:0] w_addr_nxt;
  logic [AW1-1:0]    w_row_sum;
  logic [ROM_AW-1:0] w_row_nxt;

  // Counter restarts at 1 on a level change so the new level counts as its first stable cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1   <= 1'b0;
      r_key_s2   <= 1'b0;
      r_key_s2_d <= 1'b0;
      r_key_db   <= 1'b0;
      r_key_db_d <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_key_s1   <= key_raw;
      r_key_s2   <= r_key_s1;
      r_key_s2_d <= r_key_s2;
      r_key_db_d <= r_key_db;
      if (r_key_s2 != r_key_s2_d) begin
        r_db_cnt <= DB_W'(1);
      end else if (r_key_s2 != r_key_db) begin
        if (r_db_cnt >= DB_W'(DEBOUNCE_CYC - 1)) begin
          r_key_db <= r_key_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end
  end

  assign w_key_pulse = r_key_db & ~r_key_db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_OFF;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_key_pulse) begin
      if (r_state == state_t'(NUM_BANKS)) w_state_nxt = S_OFF;
      else                                 w_state_nxt = state_t'(r_state + 3'd1);
    end
  end

  // Window bounds at 13 bits so a window near 4095 clips instead of wrapping.
  assign w_x_end  = {1'b0, r_px} + 13'(ICON_W);
  assign w_y_end  = {1'b0, r_py} + 13'(ICON_H);
  assign w_in_win = de && (pixel_x >= r_px) && ({1'b0, pixel_x} < w_x_end)
                       && (pixel_y >= r_py) && ({1'b0, pixel_y} < w_y_end);
  assign w_active = w_in_win && (r_bank_sel != '0);

  // Each row re-seeds from a running row base, keeping an ICON_W stride when the right edge clips.
  assign w_row_start = w_active && !r_active_d;
  assign w_addr      = w_row_start ? r_row_base : r_cnt;
  assign w_addr_nxt  = (w_addr == ADDR_LAST) ? '0 : w_addr + ROM_AW'(1);
  assign w_row_sum   = {1'b0, r_row_base} + AW1'(ICON_W);
  assign w_row_nxt   = (w_row_sum >= AW1'(AREA)) ? '0 : w_row_sum[ROM_AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px       <= '0;
      r_py       <= '0;
      r_bank_sel <= '0;
      r_cnt      <= '0;
      r_row_base <= '0;
      r_active_d <= 1'b0;
      r_rom_addr <= '0;
      r_rom_en   <= 1'b0;
      r_en_pipe  <= '0;
    end else begin
      r_active_d <= w_active;
      r_rom_en   <= w_active;
      r_en_pipe  <= ROM_LAT'({r_en_pipe, r_rom_en});
      if (w_active) r_rom_addr <= w_addr;
      if (frame_start) begin
        r_bank_sel <= r_state;
        r_px       <= pos_x;
        r_py       <= pos_y;
        r_cnt      <= '0;
        r_row_base <= '0;
      end else if (w_active) begin
        r_cnt <= w_addr_nxt;
        if (w_row_start) r_row_base <= w_row_nxt;
      end
    end
  end

  assign rom_addr  = r_rom_addr;
  assign rom_en    = r_rom_en;
  assign bank_sel  = r_bank_sel;
  assign ovl_valid = r_en_pipe[ROM_LAT-1];

endmodule

// File: tb/tb_osd_icon_sched.sv
// Directed bench for osd_icon_sched with a per-cycle window/address model and literal pins.
module tb_osd_icon_sched;

  localparam int ICON_W  = 50;
  localparam int ICON_H  = 50;
  localparam int ROM_AW  = 12;
  localparam int ROM_LAT = 2;
  localparam int DEB     = 4;
  localparam int NB      = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [11:0]       pixel_x = '0;
  logic [11:0]       pixel_y = '0;
  logic              de = 1'b0;
  logic              frame_start = 1'b0;
  logic              key_raw = 1'b0;
  logic [11:0]       pos_x = '0;
  logic [11:0]       pos_y = '0;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_en;
  logic [2:0]        bank_sel;
  logic              ovl_valid;

  int checks = 0;
  int errors = 0;

  int m_fsm  = 0;
  int m_bank = 0;
  int m_px   = 0;
  int m_py   = 0;
  int exp_addr = 0;
  bit exp_en = 1'b0;
  bit hist [0:ROM_LAT];

  int n_en;
  int n_ov;

  always #5 clk = ~clk;

  osd_icon_sched #(
    .ICON_W(ICON_W),
    .ICON_H(ICON_H),
    .ROM_AW(ROM_AW),
    .ROM_LAT(ROM_LAT),
    .DEBOUNCE_CYC(DEB),
    .NUM_BANKS(NB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .de(de),
    .frame_start(frame_start),
    .key_raw(key_raw),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .rom_addr(rom_addr),
    .rom_en(rom_en),
    .bank_sel(bank_sel),
    .ovl_valid(ovl_valid)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: what the outputs must show after this edge, from the inputs held before it.
  task automatic model_update();
    int x, y;
    x = int'(pixel_x);
    y = int'(pixel_y);
    if (!rst_n) begin
      m_bank = 0; m_px = 0; m_py = 0; exp_en = 1'b0;
      for (int i = 0; i <= ROM_LAT; i++) hist[i] = 1'b0;
    end else begin
      exp_en = de && (x >= m_px) && (x < m_px + ICON_W) &&
               (y >= m_py) && (y < m_py + ICON_H) && (m_bank != 0);
      if (exp_en) exp_addr = (y - m_py) * ICON_W + (x - m_px);
      for (int i = ROM_LAT; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = exp_en;
      if (frame_start) begin
        m_bank = m_fsm;
        m_px   = int'(pos_x);
        m_py   = int'(pos_y);
      end
    end
  endtask

  task automatic compare_outputs();
    chk("rom_en", int'(rom_en), int'(exp_en));
    if (exp_en) chk("rom_addr", int'(rom_addr), exp_addr);
    chk("ovl_valid", int'(ovl_valid), int'(hist[ROM_LAT]));
    chk("bank_sel", int'(bank_sel), m_bank);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_outputs();
    if (rom_en) n_en++;
    if (ovl_valid) n_ov++;
  endtask

  task automatic idle(input int n);
    de = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame();
    de = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic press(input int hold, input bit accept);
    key_raw = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    key_raw = 1'b0;
    if (accept) m_fsm = (m_fsm + 1) % (NB + 1);
    idle(12);
  endtask

  task automatic pix(input int x, input int y);
    pixel_x = 12'(x);
    pixel_y = 12'(y);
    de = 1'b1;
    tick();
  endtask

  initial begin
    int exp_seq [5];
    exp_seq = '{1, 2, 3, 4, 0};

    idle(3);
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_bank", int'(bank_sel), 0);
    rst_n = 1'b1;
    idle(2);
    frame();
    chk("bank_after_frame_nokey", int'(bank_sel), 0);

    for (int k = 0; k < 5; k++) begin
      press(10, 1'b1);
      frame();
      chk("bank_seq", int'(bank_sel), exp_seq[k]);
    end

    // 3-cycle press is below threshold, 4-cycle press is accepted.
    press(3, 1'b0);
    frame();
    chk("bank_short_glitch", int'(bank_sel), 0);
    press(4, 1'b1);
    frame();
    chk("bank_min_press", int'(bank_sel), 1);

    for (int i = 0; i < 10; i++) begin
      key_raw = ~key_raw;
      idle(2);
    end
    key_raw = 1'b0;
    idle(12);
    frame();
    chk("bank_after_bounce", int'(bank_sel), 1);

    pos_x = 12'd100;
    pos_y = 12'd20;
    frame();
    for (int y = 0; y < 75; y++) begin
      n_en = 0;
      n_ov = 0;
      for (int x = 0; x < 256; x++) begin
        pix(x, y);
        if (x == 100 && y == 20) chk("first_addr", int'(rom_addr), 0);
        if (x == 149 && y == 69) chk("last_addr", int'(rom_addr), 2499);
      end
      idle(8);
      chk("row_en_count", n_en, (y >= 20 && y < 70) ? 50 : 0);
      chk("row_ovl_count", n_ov, (y >= 20 && y < 70) ? 50 : 0);
    end

    pos_x = 12'd4080;
    pos_y = 12'd100;
    frame();
    for (int y = 100; y < 103; y++) begin
      n_en = 0;
      for (int x = 4060; x < 4096; x++) begin
        pix(x, y);
        if (x == 4095 && y == 100) chk("clip_row0_last", int'(rom_addr), 15);
        if (x == 4080 && y == 101) chk("clip_row1_first", int'(rom_addr), 50);
        if (x == 4080 && y == 102) chk("clip_row2_first", int'(rom_addr), 100);
      end
      idle(8);
      chk("clip_row_count", n_en, 16);
    end

    pos_x = 12'd100;
    pos_y = 12'd20;
    frame();
    for (int x = 90; x < 106; x++) pix(x, 20);
    chk("pre_reset_rom_en", int'(rom_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rom_en", int'(rom_en), 0);
    chk("async_rst_rom_addr", int'(rom_addr), 0);
    chk("async_rst_bank", int'(bank_sel), 0);
    chk("async_rst_ovl", int'(ovl_valid), 0);
    m_fsm = 0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    frame();
    chk("post_rst_bank", int'(bank_sel), 0);
    n_en = 0;
    for (int x = 90; x < 160; x++) pix(x, 20);
    idle(8);
    chk("post_rst_no_en", n_en, 0);

    press(10, 1'b1);
    frame();
    chk("post_rst_bank_key", int'(bank_sel), 1);
    n_en = 0;
    for (int x = 90; x < 160; x++) begin
      pix(x, 20);
      if (x == 100) chk("post_rst_first_addr", int'(rom_addr), 0);
    end
    idle(8);
    chk("post_rst_row_count", n_en, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_icon_sched.md
# osd_icon_sched

Read-side scheduler for the on-screen icon overlay ROM banks. It debounces the user key and steps the active colour bank. It generates the ROM read address and enable for a 50x50 icon window at a programmable screen position. It also emits an overlay-valid strobe aligned to ROM output latency, so the pixel mixer can select the bank data. All bank and position changes take effect only at frame start, so the icon never tears.

## Interface
- ICON_W, 50, icon width in pixels
- ICON_H, 50, icon height in pixels
- ROM_AW, 12, ROM address width; ICON_W*ICON_H must be at most 2^ROM_AW
- ROM_LAT, 1, ROM read latency in clk cycles (1..4)
- DEBOUNCE_CYC, 1000000, cycles the key input must be stable before it is accepted
- NUM_BANKS, 4, number of colour banks

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- pixel_x  in  12  current pixel column
- pixel_y  in  12  current pixel row
- de  in  1  active-video enable
- frame_start  in  1  one-cycle pulse before the first active pixel of a frame
- key_raw  in  1  asynchronous push button, active-high
- pos_x  in  12  icon left edge, sampled at frame_start
- pos_y  in  12  icon top edge, sampled at frame_start
- rom_addr  out  ROM_AW  ROM read address (registered)
- rom_en  out  1  ROM read enable (registered)
- bank_sel  out  3  active bank: 0 = overlay off, 1..NUM_BANKS = bank
- ovl_valid  out  1  high when the ROM output belongs to an in-window pixel

## Operation
- **Key path.**
  - key_raw passes through a 2-FF synchroniser.
  - A debounce counter restarts on every change of the synchronised level.
  - When the level has been stable for DEBOUNCE_CYC cycles, the debounced level updates.
  - A rising edge of the debounced level produces a one-cycle key_pulse.
- **Bank FSM.**
  - States: OFF, B1..B(NUM_BANKS). Reset state is OFF.
  - key_pulse advances OFF to B1, Bk to Bk+1, and B(NUM_BANKS) back to OFF.
  - With no key_pulse, the state holds.
- **Frame latch.**
  - On frame_start, bank_sel takes the FSM state (OFF = 0, Bk = k).
  - pos_x and pos_y are latched into 12-bit registers.
  - The address counter clears to 0.
  - A key_pulse arriving in the same cycle as frame_start updates the FSM only; it shows at the next frame_start.
- **Window test.**
  - in_win = de AND pixel_x >= px AND pixel_x < px+ICON_W AND pixel_y >= py AND pixel_y < py+ICON_H.
  - Sums are computed at 13 bits, so windows near 4095 are clipped rather than wrapped.
- **Address counter.**
  - Increments once per cycle with in_win AND bank_sel != 0.
  - Wraps to 0 after value ICON_W*ICON_H-1.
  - Raster order makes this equal to (y-py)*ICON_W + (x-px).
- **Outputs.**
  - rom_addr is the registered counter value for the in-window pixel.
  - rom_en is registered (in_win AND bank_sel != 0).
  - ovl_valid is rom_en delayed by ROM_LAT cycles.
  - When bank_sel = 0, rom_en and ovl_valid stay 0 and the counter holds.

## Timing
- Reset values: rom_addr = 0, rom_en = 0, bank_sel = 0, ovl_valid = 0, FSM = OFF, counters = 0, latched position = 0.
- Reset asserted mid-frame clears everything immediately. The overlay stays off until both a key press and a frame_start have occurred.
- Pixel presented at cycle t: rom_addr and rom_en valid at t+1, ovl_valid at t+1+ROM_LAT.
- Key latency: about 2 + DEBOUNCE_CYC + 1 cycles from a stable key_raw edge to key_pulse.
- A release edge never produces a pulse. A glitch shorter than DEBOUNCE_CYC produces nothing.
- bank_sel changes only in the cycle after frame_start.

## Test plan
1. Reset, frame_start, DEBOUNCE_CYC=4, key pressed and held 10 cycles -> exactly one key_pulse. After the next frame_start, bank_sel = 1.
2. Five debounced presses with a frame_start after each -> bank_sel sequence 1, 2, 3, 4, 0.
3. Bank 1, pos_x=100, pos_y=20, full 1920-wide raster with de:
   - rom_en high for exactly 50 cycles on each of rows 20..69.
   - First rom_addr = 0 at pixel (100,20); last rom_addr = 2499 at pixel (149,69).
   - ovl_valid lags rom_en by exactly ROM_LAT.
4. pos_x=4080 -> only columns 4080..4095 are in-window (clipped, no wrap); the row stride is still 50.
5. key_raw toggles every 2 cycles for 20 cycles with DEBOUNCE_CYC=4 -> no key_pulse and no bank change.
6. rst_n asserted mid-window while rom_en=1 -> all outputs 0 the same cycle, and they remain 0 after release until a key press plus frame_start.
